// File: rtl/grid_update_scheduler.sv
// Owns the 16x12 RGB444 color grid for the VGA block. Arbitrates two cell-write
// requesters into a FIFO and applies queued writes and full-grid clears only in vblank.
module grid_update_scheduler #(
  parameter int CELLS  = 192,
  parameter int DEPTH  = 8,
  parameter int VLINES = 480
) (
  input  logic        vgaclk,
  input  logic        rst,
  input  logic [9:0]  vc,
  input  logic        req0_valid,
  input  logic [7:0]  req0_idx,
  input  logic [11:0] req0_color,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_idx,
  input  logic [11:0] req1_color,
  output logic        req1_ready,
  input  logic        clr_start,
  input  logic [11:0] clr_color,
  output logic        clr_busy,
  output logic        frame_done,
  output logic        bad_idx,
  output logic [11:0] vgaColors [0:CELLS-1]
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL     = (AW+1)'(DEPTH);
  localparam logic [9:0]     VL       = 10'(VLINES);
  localparam logic [8:0]     CELLS_W  = 9'(CELLS);
  localparam logic [7:0]     CELLS_M1 = 8'(CELLS - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [7:0]    ca_q, ca_d;
  logic          clr_busy_q, clr_busy_d;
  logic [11:0]   clr_color_q, clr_color_d;
  logic          vblank_q;
  logic          last_q, last_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic [19:0]   mem_q [DEPTH];
  logic [11:0]   grid_q [0:CELLS-1];

  logic          vblank, full, grant0, grant1, push, pop, bad;
  logic [19:0]   push_data, head;
  logic          wr_en;
  logic [7:0]    wr_addr;
  logic [11:0]   wr_data;

  assign vblank     = (vc >= VL);
  assign frame_done = rst & vblank & ~vblank_q;
  assign clr_busy   = clr_busy_q;
  assign bad_idx    = bad;
  assign vgaColors  = grid_q;

  // last_q = 1 means requester 1 won the previous grant, so requester 0 wins a tie.
  always_comb begin
    full       = (count_q == FULL);
    req0_ready = ~full & (~req1_valid | last_q);
    req1_ready = ~full & (~req0_valid | ~last_q);
    grant0     = req0_valid & req0_ready;
    grant1     = req1_valid & req1_ready;
    push       = grant0 | grant1;
    push_data  = grant0 ? {req0_idx, req0_color} : {req1_idx, req1_color};
    last_d     = grant0 ? 1'b0 : (grant1 ? 1'b1 : last_q);
    head       = mem_q[rp_q];
    pop        = (state_q == DRAIN) & vblank & ~clr_busy_q & (count_q != '0);
    bad        = pop & ({1'b0, head[19:12]} >= CELLS_W);
    wp_d       = wp_q + AW'(push);
    rp_d       = rp_q + AW'(pop);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ca_d        = ca_q;
    clr_busy_d  = clr_busy_q;
    clr_color_d = clr_color_q;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    if (clr_start && !clr_busy_q) begin
      clr_busy_d  = 1'b1;
      clr_color_d = clr_color;
    end
    case (state_q)
      IDLE: begin
        if (vblank && clr_busy_q)              state_d = CLEAR;
        else if (vblank && count_q != '0)      state_d = DRAIN;
      end
      CLEAR: begin
        if (!vblank) begin
          state_d = IDLE;
        end else begin
          wr_en   = 1'b1;
          wr_addr = ca_q;
          wr_data = clr_color_q;
          if (ca_q == CELLS_M1) begin
            ca_d       = '0;
            clr_busy_d = 1'b0;
            state_d    = IDLE;
          end else begin
            ca_d = ca_q + 8'd1;
          end
        end
      end
      DRAIN: begin
        if (pop && !bad) begin
          wr_en   = 1'b1;
          wr_addr = head[19:12];
          wr_data = head[11:0];
        end
        // A newly pending clear must run before any further queued writes.
        if (!vblank || clr_busy_q || count_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge vgaclk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ca_q        <= '0;
      clr_busy_q  <= 1'b0;
      clr_color_q <= '0;
      vblank_q    <= 1'b0;
      last_q      <= 1'b1;
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      ca_q        <= ca_d;
      clr_busy_q  <= clr_busy_d;
      clr_color_q <= clr_color_d;
      vblank_q    <= vblank;
      last_q      <= last_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge vgaclk) begin
    if (push) mem_q[wp_q] <= push_data;
  end

  always_ff @(posedge vgaclk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < CELLS; i++) grid_q[i] <= '0;
    end else if (wr_en) begin
      grid_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_grid_update_scheduler.sv
// Self-checking bench for grid_update_scheduler: directed vector table, corner-case
// sequences and randomized traffic against a blank-level reference model.
module tb_grid_update_scheduler;

  localparam int CELLS  = 192;
  localparam int DEPTH  = 8;
  localparam int VLINES = 480;

  logic        vgaclk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  vc = '0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0]  req0_idx = '0, req1_idx = '0;
  logic [11:0] req0_color = '0, req1_color = '0;
  logic        req0_ready, req1_ready;
  logic        clr_start = 1'b0;
  logic [11:0] clr_color = '0;
  logic        clr_busy, frame_done, bad_idx;
  logic [11:0] colors [0:CELLS-1];

  always #5 vgaclk = ~vgaclk;

  grid_update_scheduler #(.CELLS(CELLS), .DEPTH(DEPTH), .VLINES(VLINES)) dut (
    .vgaclk(vgaclk), .rst(rst), .vc(vc),
    .req0_valid(req0_valid), .req0_idx(req0_idx), .req0_color(req0_color), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_idx(req1_idx), .req1_color(req1_color), .req1_ready(req1_ready),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
    .frame_done(frame_done), .bad_idx(bad_idx), .vgaColors(colors)
  );

  int n_pass = 0, n_total = 0;
  int fd_cnt = 0, bad_cnt = 0;
  int fd0, b0;

  always @(negedge vgaclk) begin
    if (frame_done) fd_cnt++;
    if (bad_idx) bad_cnt++;
  end

  // Reference model: grid contents, pending writes in acceptance order, pending clear.
  logic [11:0] mgrid [CELLS];
  logic [19:0] mq [$];
  bit          mlast;
  bit          mclr;
  logic [11:0] mcol;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic step();
    @(posedge vgaclk);
    #1;
  endtask

  task automatic model_reset();
    foreach (mgrid[i]) mgrid[i] = '0;
    mq.delete();
    mlast = 1'b1;
    mclr  = 1'b0;
    mcol  = '0;
  endtask

  task automatic model_blank(output int exp_bad);
    exp_bad = 0;
    if (mclr) begin
      foreach (mgrid[i]) mgrid[i] = mcol;
      mclr = 1'b0;
    end
    foreach (mq[k]) begin
      if (int'(mq[k][19:12]) < CELLS) mgrid[mq[k][19:12]] = mq[k][11:0];
      else exp_bad++;
    end
    mq.delete();
  endtask

  task automatic compare_grid(input string name);
    int diff;
    diff = 0;
    for (int i = 0; i < CELLS; i++) begin
      if (colors[i] !== mgrid[i]) begin
        if (diff == 0) $display("  %s: cell %0d dut %h model %h", name, i, colors[i], mgrid[i]);
        diff++;
      end
    end
    chk(name, diff, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0; vc = '0;
    req0_valid = 1'b0; req1_valid = 1'b0; clr_start = 1'b0;
    step(); step();
    rst = 1'b1;
    model_reset();
    step();
  endtask

  task automatic cyc(input bit v0, input logic [7:0] i0, input logic [11:0] c0,
                     input bit v1, input logic [7:0] i1, input logic [11:0] c1,
                     input bit clr, input logic [11:0] ccol, output bit a0, output bit a1);
    bit full, e0, e1;
    req0_valid = v0; req0_idx = i0; req0_color = c0;
    req1_valid = v1; req1_idx = i1; req1_color = c1;
    clr_start = clr; clr_color = ccol;
    #1;
    full = (mq.size() >= DEPTH);
    e0 = v0 && !full && (!v1 || mlast);
    e1 = v1 && !full && (!v0 || !mlast);
    a0 = req0_valid & req0_ready;
    a1 = req1_valid & req1_ready;
    chk("grant0", int'(a0), int'(e0));
    chk("grant1", int'(a1), int'(e1));
    if (e0) begin mq.push_back({i0, c0}); mlast = 1'b0; end
    else if (e1) begin mq.push_back({i1, c1}); mlast = 1'b1; end
    if (clr && !mclr) begin mclr = 1'b1; mcol = ccol; end
    @(posedge vgaclk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0; clr_start = 1'b0;
    if (vc < VLINES) chk("clr_busy", int'(clr_busy), int'(mclr));
  endtask

  task automatic start_blank();
    fd0 = fd_cnt;
    b0  = bad_cnt;
    vc  = 10'd480;
  endtask

  task automatic end_blank(input string name);
    int eb;
    vc = '0;
    step();
    model_blank(eb);
    compare_grid({name, "_grid"});
    chk({name, "_bad_pulses"}, bad_cnt - b0, eb);
    chk({name, "_frame_done_pulses"}, fd_cnt - fd0, 1);
    chk({name, "_clr_busy_idle"}, int'(clr_busy), 0);
  endtask

  typedef struct {
    bit v0; bit v1;
    logic [7:0] i0; logic [11:0] c0;
    logic [7:0] i1; logic [11:0] c1;
    bit e0; bit e1;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ga0, ga1, found;
    int n_done, n_untouched, nz;
    tbl[0]  = '{1'b1, 1'b1, 8'd10,  12'h101, 8'd100, 12'h201, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'd11,  12'h102, 8'd101, 12'h202, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 8'd20,  12'h111, 8'd0,   12'h000, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'd20,  12'h222, 8'd0,   12'h000, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 8'd12,  12'h103, 8'd102, 12'h203, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 8'd0,   12'h000, 8'd0,   12'h000, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'd0,   12'h000, 8'd103, 12'h204, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 8'd13,  12'h104, 8'd104, 12'h205, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 8'd14,  12'h105, 8'd105, 12'h206, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 8'd15,  12'h106, 8'd106, 12'h207, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 8'd16,  12'h107, 8'd0,   12'h000, 1'b0, 1'b0};

    // Reset values and a single write held back until blank.
    do_reset();
    compare_grid("reset_grid");
    chk("reset_clr_busy", int'(clr_busy), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_bad_idx", int'(bad_idx), 0);
    cyc(1'b1, 8'd5, 12'hF00, 1'b0, 8'd0, 12'h0, 1'b0, 12'h0, ga0, ga1);
    chk("t1_req0_ready", int'(ga0), 1);
    repeat (4) step();
    chk("t1_cell5_active", int'(colors[5]), 0);
    start_blank();
    found = 1'b0;
    for (int k = 0; k < 3 && !found; k++) begin
      step();
      if (colors[5] == 12'hF00) found = 1'b1;
    end
    chk("t1_cell5_within3", int'(found), 1);
    end_blank("t1");

    // Arbitration table: alternation on ties, queue full after 8 grants.
    do_reset();
    for (int r = 0; r < 11; r++) begin
      cyc(tbl[r].v0, tbl[r].i0, tbl[r].c0, tbl[r].v1, tbl[r].i1, tbl[r].c1, 1'b0, 12'h0, ga0, ga1);
      chk($sformatf("tbl%0d_g0", r), int'(ga0), int'(tbl[r].e0));
      chk($sformatf("tbl%0d_g1", r), int'(ga1), int'(tbl[r].e1));
    end
    start_blank();
    repeat (40) step();
    end_blank("t2");
    chk("t2_cell20_fifo_order", int'(colors[20]), 12'h222);

    // Clear pending ahead of a queued write to the last cell.
    cyc(1'b0, 8'd0, 12'h0, 1'b0, 8'd0, 12'h0, 1'b1, 12'h0A0, ga0, ga1);
    cyc(1'b1, 8'd191, 12'hFFF, 1'b0, 8'd0, 12'h0, 1'b0, 12'h0, ga0, ga1);
    start_blank();
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      step();
      if (!clr_busy) found = 1'b1;
    end
    chk("t3_clr_busy_fell", int'(found), 1);
    chk("t3_cell191_at_busy_fall", int'(colors[191]), 12'h0A0);
    repeat (20) step();
    end_blank("t3");
    chk("t3_cell191_final", int'(colors[191]), 12'hFFF);

    // Clear paused by a short blank, resumed on the next one.
    do_reset();
    cyc(1'b0, 8'd0, 12'h0, 1'b0, 8'd0, 12'h0, 1'b1, 12'h5A5, ga0, ga1);
    start_blank();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (colors[0] == 12'h5A5) found = 1'b1;
    end
    chk("t4_clear_started", int'(found), 1);
    repeat (49) step();
    vc = '0;
    repeat (3) step();
    n_done = 0; n_untouched = 0;
    for (int i = 0; i < CELLS; i++) begin
      if (i < 50 && colors[i] == 12'h5A5) n_done++;
      if (i >= 50 && colors[i] == 12'h000) n_untouched++;
    end
    chk("t4_cells_done", n_done, 50);
    chk("t4_cells_untouched", n_untouched, CELLS - 50);
    chk("t4_busy_in_gap", int'(clr_busy), 1);
    start_blank();
    repeat (250) step();
    end_blank("t4");

    // Out-of-range index pushed during blank.
    start_blank();
    repeat (3) step();
    cyc(1'b1, 8'd200, 12'h0F0, 1'b0, 8'd0, 12'h0, 1'b0, 12'h0, ga0, ga1);
    repeat (5) step();
    chk("t5_bad_pulse_count", bad_cnt - b0, 1);
    compare_grid("t5_grid_unchanged");
    end_blank("t5");

    // vc sweep across the blank boundary.
    fd0 = fd_cnt;
    vc = 10'd479; step();
    vc = 10'd480; step();
    vc = 10'd481; step(); step();
    chk("t6_frame_done_once", fd_cnt - fd0, 1);
    vc = '0; step();

    // Reset while draining.
    cyc(1'b1, 8'd7, 12'h777, 1'b1, 8'd210, 12'h888, 1'b0, 12'h0, ga0, ga1);
    cyc(1'b1, 8'd8, 12'h999, 1'b1, 8'd9, 12'hAAA, 1'b0, 12'h0, ga0, ga1);
    vc = 10'd480;
    repeat (3) step();
    rst = 1'b0;
    #1;
    nz = 0;
    for (int i = 0; i < CELLS; i++) if (colors[i] != 12'h000) nz++;
    chk("t6_rst_grid_zero", nz, 0);
    chk("t6_rst_clr_busy", int'(clr_busy), 0);
    chk("t6_rst_frame_done", int'(frame_done), 0);
    chk("t6_rst_bad_idx", int'(bad_idx), 0);
    do_reset();

    // Randomized traffic checked against the model at each blank.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 24; k++) begin
        cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 207)), 12'($urandom),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 207)), 12'($urandom),
            ($urandom_range(0, 15) == 0), 12'($urandom), ga0, ga1);
      end
      compare_grid($sformatf("rnd%0d_active_grid", r));
      start_blank();
      repeat (260) step();
      end_blank($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/grid_update_scheduler.md
# grid_update_scheduler

Owns the 16x12 color-cell grid (192 cells, 12-bit RGB444 each) that drives the `vga` block's `vgaColors` input. It arbitrates cell-write requests from two requesters (e.g. game logic and score/overlay logic) and queues them. Queued writes and full-grid clears are applied only during vertical blanking, so a frame never shows a partially updated grid.

## Interface
Parameters:
- `CELLS`, 192: number of grid cells; valid indices are 0..CELLS-1.
- `DEPTH`, 8: write-queue depth in entries; power of two.
- `VLINES`, 480: active lines; `vc >= VLINES` means vertical blanking.

Ports:
- `vgaclk`  in  1  pixel clock; the only clock.
- `rst`  in  1  reset; asynchronous assert, active-low.
- `vc`  in  10  vertical line counter from `vga`; registered in the `vgaclk` domain.
- `req0_valid`  in  1  requester 0 write request.
- `req0_idx`  in  8  requester 0 cell index.
- `req0_color`  in  12  requester 0 color, {r,g,b}.
- `req0_ready`  out  1  requester 0 grant; the transfer occurs on `valid & ready`.
- `req1_valid`, `req1_idx`, `req1_color`, `req1_ready`: same as requester 0.
- `clr_start`  in  1  one-cycle pulse; requests a fill of all cells.
- `clr_color`  in  12  fill color; sampled on the cycle `clr_start` is accepted.
- `clr_busy`  out  1  a clear is pending or in progress.
- `frame_done`  out  1  one-cycle pulse at the start of each vertical blank.
- `bad_idx`  out  1  one-cycle pulse when a popped entry has `idx >= CELLS`.
- `vgaColors`  out  12 x [0:CELLS-1]  registered grid; connects to `vga.vgaColors`.

## Operation
- `vblank = (vc >= VLINES)`. The block registers it as `vblank_d`. `frame_done = vblank & ~vblank_d`.
- Arbiter:
  - Grants are issued only when queue count < DEPTH. A pop in the same cycle does not free space early.
  - Only one requester is granted per cycle.
  - If exactly one requester is valid, that requester is granted.
  - If both are valid, the one not granted last is granted. A last-grant register holds this choice and updates only on a grant.
  - Ready signals are combinational from the valid inputs, the queue count and the last-grant register.
  - `ready` may be high with `valid` low; in that case nothing transfers.
- Queue: FIFO of {idx[7:0], color[11:0]}. Push and pop may occur in the same cycle; the count is then unchanged.
- FSM states:
  - IDLE: the default state.
  - CLEAR: sweeps cell address `ca` through 0..CELLS-1 and writes `clr_color_q` to `vgaColors[ca]`, one cell per cycle.
  - DRAIN: pops one entry per cycle. If `idx < CELLS`, writes `vgaColors[idx] <= color`. Otherwise discards the entry and pulses `bad_idx`.
- Clear acceptance: `clr_start` is accepted only when `clr_busy == 0`. Acceptance captures `clr_color_q` and sets `clr_busy` on the next edge. `clr_start` while busy is ignored.
- FSM transitions, evaluated each cycle:
  - IDLE -> CLEAR if `vblank & clr_busy`.
  - IDLE -> DRAIN if `vblank & ~clr_busy & count != 0`.
  - CLEAR -> IDLE after the `ca == CELLS-1` write, which also clears `clr_busy` and resets `ca` to 0.
  - CLEAR -> IDLE (paused) if `vblank` falls. `ca` is held, and the clear resumes at `ca` on the next blank.
  - DRAIN -> IDLE when `vblank` falls, or when count reaches 0 with no push in that cycle.
- Ordering:
  - A pending clear always completes before the queue drains. Writes queued before or during a clear are therefore applied after it, and the later writes win.
  - Within the queue, writes to the same cell apply in FIFO order.
- Width rules: `idx` is compared unsigned against CELLS. `ca` is 8 bits.
- Reset, asynchronous active-low, sets:
  - `vgaColors` all 0; queue empty; count 0.
  - Last-grant = requester 1, so requester 0 wins the first tie.
  - FSM in IDLE; `ca` = 0; `clr_busy` = 0; `frame_done` = 0; `bad_idx` = 0; `vblank_d` = 0.
- Reset mid-clear or mid-drain abandons the operation. No partial state survives.

## Timing
- Request accept at edge t: the entry is in the queue after edge t. The earliest grid update is at edge t+1, and only if `vblank` is true at t+1.
- During active video (`vc < VLINES`), `vgaColors` never changes.
- DRAIN rate is 1 write/cycle. The first pop occurs on the cycle after the FSM enters DRAIN. Entry is from IDLE, registered.
- CLEAR runs CELLS cycles within a blank, plus 1 entry cycle. With 45 blank lines x 800 clocks, a clear always completes in one blank. The pause path exists for a short or absent blank.
- `frame_done` asserts on the first cycle with `vblank = 1` after a cycle with `vblank = 0`.
- `bad_idx` asserts in the same cycle as the discarding pop.

## Test plan
- Reset, then hold `vc = 0`; push req0 idx 5 color 12'hF00 -> `req0_ready = 1`, `vgaColors[5]` stays 0; set `vc = 480` -> `vgaColors[5] = 12'hF00` within 3 cycles.
- Both requesters valid continuously for 8 cycles with `vc = 0` -> grants alternate 0,1,0,1...; queue full after 8 grants; both readies 0 until a pop.
- `clr_start` with `clr_color = 12'h0A0`, then queued write idx 191 color 12'hFFF, then `vc = 480` -> all cells 12'h0A0 except cell 191 = 12'hFFF; `clr_busy` falls after the write at `ca = 191`.
- Clear started, then `vc` drops to 0 after 50 clear cycles -> cells 0..49 updated and 50..191 unchanged; the next blank finishes 50..191; `clr_busy` stays 1 across the gap.
- Push idx 200 during blank -> `bad_idx` one-cycle pulse; no `vgaColors` change.
- Sweep `vc` 479->480->481 -> exactly one `frame_done` pulse; assert `rst = 0` mid-drain -> all outputs at reset values immediately.
